divider: RTL and testbench
==========================

// Module: divider
// PURPOSE
//  Iterative restoring divider for the RV32M DIV/DIVU/REM/REMU ops; the inverse-operation companion to the
//  shift-add multiplier, and it uses the same start/ready/done handshake so the EX stage drives both identically.
//  It accepts one operation when idle and produces quotient and remainder after WIDTH iterations, or after
//  1 cycle for special cases. Results are registered and held until the next accepted start.
// PARAMETERS
//  WIDTH  32  operand/result width; iteration counter is $clog2(WIDTH)+1 bits
// PORTS
//  clk_i        in   1      clock; all state updates on posedge
//  rst_i        in   1      asynchronous, active-high reset
//  signed_i     in   1      1: DIV/REM (two's complement), 0: DIVU/REMU; sampled at accepted start
//  dividend_i   in   WIDTH  dividend; sampled at accepted start
//  divisor_i    in   WIDTH  divisor; sampled at accepted start
//  start_i      in   1      request; accepted only when start_i & ready_o at posedge
//  ready_o      out  1      idle/able to accept (IDLE or DONE)
//  done_o       out  1      results valid; held until next accepted start
//  quotient_o   out  WIDTH  registered quotient
//  remainder_o  out  WIDTH  registered remainder
// BEHAVIOUR
//  Reset (async, any time incl. mid-op): state IDLE, ready_o=1, done_o=0, quotient_o=0, remainder_o=0, counter=0.
//  States: IDLE -> (accept) -> SHIFT_SUB | DONE(special); SHIFT_SUB -> DONE when iteration==WIDTH; DONE -> (accept) as IDLE.
//  Accept edge: latch neg_q = signed_i & (dividend[MSB]^divisor[MSB]) & (divisor!=0); neg_r = signed_i & dividend[MSB];
//   D = |divisor| (signed) or divisor; Q = |dividend| or dividend; R=0; ready_o=0, done_o=0 next cycle.
//   |x| of 0x8000_0000 is 0x8000_0000 treated unsigned (no overflow in magnitude path).
//  Special cases resolved at accept, skip SHIFT_SUB, enter DONE directly (done_o=1 on the following cycle):
//   divisor==0: quotient=all-ones, remainder=dividend (both signed/unsigned).
//   signed & dividend==0x8000_0000 & divisor==all-ones: quotient=0x8000_0000, remainder=0.
//  SHIFT_SUB, one iteration per cycle: {R,Q} <<= 1; T = {1'b0,R} - {1'b0,D} (WIDTH+1 bits);
//   if T[WIDTH]==0 then R=T[WIDTH-1:0], Q[0]=1; iteration+=1.
//  On the edge completing iteration WIDTH: quotient_o = neg_q ? -Q : Q; remainder_o = neg_r ? -R : R;
//   state DONE, done_o=1, ready_o=1. Normal latency: done_o rises WIDTH+1 edges after the accept edge.
//  start_i while ready_o=0: ignored and has no effect on state (no queueing). Operand changes while busy: no effect.
//  start_i in DONE: accepted; done_o drops the next cycle; quotient_o/remainder_o keep old values until the new result.
//  start_i held high continuously: a new op is accepted at every cycle in which ready_o=1 (back-to-back).
//  Outputs are never combinationally dependent on inputs.
// STRUCTURE
//  Package div_types: dop_e {D_IDLE, D_SHIFT_SUB, D_DONE}; dstate_s {ready, done, op, iteration, R, Q, D,
//   neg_q, neg_r}; helper functions abs_val(), negate_if().
//  No sub-module: a single always_ff register of dstate_s, with next state computed in always_comb by
//   init()/special()/shift_sub() functions.
// TESTING
//  1 unsigned 100/7: expected q=14, r=2, with done_o rising exactly 33 edges after accept and ready_o low in between.
//  2 signed -7/2 (0xFFFFFFF9/0x2): expected q=0xFFFFFFFD, r=0xFFFFFFFF. 7/-2: expected q=0xFFFFFFFD, r=1.
//  3 div-by-zero 5/0, signed and unsigned: expected q=0xFFFFFFFF, r=5, with done_o one cycle after accept.
//  4 overflow signed 0x80000000/0xFFFFFFFF: expected q=0x80000000, r=0, 1-cycle. The same operands unsigned give q=0, r=0x80000000 after 33.
//  5 start_i pulsed at iteration 10 with new operands: ignored, so the first result is unchanged. Reset asserted at iteration 20 must give
//    ready_o=1, done_o=0, outputs 0 immediately (async); a new op after that completes correctly.
//  6 Back-to-back: start_i held high for 1000 random ops (signed/unsigned mix, include 0, ±1, MIN, MAX):
//    every result must match the RISC-V reference model, and each new accept must fall on the same edge as done/ready.

Source files
------------

// File: rtl/divider_pkg.sv
// Types and next-state helpers for the iterative restoring divider.
// One packed state record holds the handshake flags, the working registers
// and the held results. The top module registers it and picks one helper
// per cycle to compute its next value.
package div_types;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH) + 1;

  typedef logic [DIV_WIDTH-1:0] word_t;
  typedef logic [CNT_W-1:0]     cnt_t;

  typedef enum logic [1:0] {
    D_IDLE      = 2'd0,
    D_SHIFT_SUB = 2'd1,
    D_DONE      = 2'd2
  } dop_e;

  typedef struct packed {
    logic  ready;      // able to accept a new operation
    logic  done;       // quot/rem hold a valid result
    dop_e  op;         // current phase
    cnt_t  iteration;  // completed shift/subtract steps
    word_t R;          // partial remainder (magnitude)
    word_t Q;          // dividend shifting out / quotient shifting in
    word_t D;          // divisor magnitude
    logic  neg_q;      // final quotient must be negated
    logic  neg_r;      // final remainder must be negated
    word_t quot;       // held quotient result
    word_t rem;        // held remainder result
  } dstate_s;

  localparam word_t WORD_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

  localparam dstate_s DSTATE_RESET = '{
    ready:     1'b1,
    done:      1'b0,
    op:        D_IDLE,
    iteration: '0,
    R:         '0,
    Q:         '0,
    D:         '0,
    neg_q:     1'b0,
    neg_r:     1'b0,
    quot:      '0,
    rem:       '0
  };

  // Magnitude of a two's complement value; the most negative value maps to
  // itself, which is its correct magnitude when read as unsigned.
  function automatic word_t abs_val(input word_t x, input logic is_signed);
    return (is_signed && x[DIV_WIDTH-1]) ? word_t'(~x + word_t'(1)) : x;
  endfunction

  function automatic word_t negate_if(input word_t x, input logic neg);
    return neg ? word_t'(~x + word_t'(1)) : x;
  endfunction

  // Divide-by-zero and signed MIN / -1 are answered without iterating.
  function automatic logic is_special(input logic is_signed, input word_t a,
                                      input word_t b);
    return (b == '0) || (is_signed && (a == WORD_MIN) && (b == '1));
  endfunction

  // Accepted regular operation: load magnitudes and sign fix-up flags.
  // Held results are left untouched until the new result is ready.
  function automatic dstate_s init(input dstate_s cur, input logic is_signed,
                                   input word_t a, input word_t b);
    dstate_s nxt;
    nxt           = cur;
    nxt.ready     = 1'b0;
    nxt.done      = 1'b0;
    nxt.op        = D_SHIFT_SUB;
    nxt.iteration = '0;
    nxt.R         = '0;
    nxt.Q         = abs_val(a, is_signed);
    nxt.D         = abs_val(b, is_signed);
    nxt.neg_q     = is_signed & (a[DIV_WIDTH-1] ^ b[DIV_WIDTH-1]) & (b != '0);
    nxt.neg_r     = is_signed & a[DIV_WIDTH-1];
    return nxt;
  endfunction

  // Accepted special operation: result is written immediately.
  function automatic dstate_s special(input dstate_s cur, input word_t a,
                                      input word_t b);
    dstate_s nxt;
    nxt           = cur;
    nxt.ready     = 1'b1;
    nxt.done      = 1'b1;
    nxt.op        = D_DONE;
    nxt.iteration = '0;
    nxt.neg_q     = 1'b0;
    nxt.neg_r     = 1'b0;
    if (b == '0) begin
      nxt.quot = '1;
      nxt.rem  = a;
    end else begin
      nxt.quot = WORD_MIN;
      nxt.rem  = '0;
    end
    return nxt;
  endfunction

  // One restoring step per call; once all steps are done, apply the sign
  // fix-ups and publish the result.
  function automatic dstate_s shift_sub(input dstate_s cur);
    dstate_s            nxt;
    logic [DIV_WIDTH:0] t;
    nxt = cur;
    if (cur.iteration == cnt_t'(DIV_WIDTH)) begin
      nxt.quot  = negate_if(cur.Q, cur.neg_q);
      nxt.rem   = negate_if(cur.R, cur.neg_r);
      nxt.op    = D_DONE;
      nxt.ready = 1'b1;
      nxt.done  = 1'b1;
    end else begin
      {nxt.R, nxt.Q} = {cur.R, cur.Q} << 1;
      t = {1'b0, nxt.R} - {1'b0, cur.D};
      if (!t[DIV_WIDTH]) begin
        nxt.R    = t[DIV_WIDTH-1:0];
        nxt.Q[0] = 1'b1;
      end
      nxt.iteration = cur.iteration + cnt_t'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/divider.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// Shares the start/ready/done handshake with the shift-add multiplier.
// Regular operations finish WIDTH+1 edges after the accept edge. Special
// cases (divide by zero, signed overflow) finish on the accept edge itself.
// The divider is sized by div_types::DIV_WIDTH; WIDTH must equal it.
module divider
  import div_types::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             start_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  dstate_s state_q;
  dstate_s state_d;
  logic    accept;

  // Next state: accept a new op when ready, otherwise advance the iteration.
  always_comb begin
    state_d = state_q;
    accept  = start_i & state_q.ready;
    if (accept) begin
      if (is_special(signed_i, dividend_i, divisor_i)) begin
        state_d = special(state_q, dividend_i, divisor_i);
      end else begin
        state_d = init(state_q, signed_i, dividend_i, divisor_i);
      end
    end else if (state_q.op == D_SHIFT_SUB) begin
      state_d = shift_sub(state_q);
    end
  end

  // State register with asynchronous reset back to idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= DSTATE_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  assign ready_o     = state_q.ready;
  assign done_o      = state_q.done;
  assign quotient_o  = state_q.quot;
  assign remainder_o = state_q.rem;

endmodule

// File: tb/tb_divider.sv
// Randomised scoreboard bench for the divider: expectations come from plain
// RISC-V division arithmetic and are queued at each accept edge. A monitor
// compares every fresh result, checks its latency and checks that the
// divider stays busy while an operation is outstanding.
module tb_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        start_i;
  logic        ready_o;
  logic        done_o;
  logic [31:0] quotient_o;
  logic [31:0] remainder_o;

  divider #(.WIDTH(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .start_i    (start_i),
    .ready_o    (ready_o),
    .done_o     (done_o),
    .quotient_o (quotient_o),
    .remainder_o(remainder_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;  // edges from accept edge to the edge publishing the result
    int          acc;  // index of the accept edge
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_txn = 0;
  logic prev_done = 1'b0;
  logic prev_acc = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RISC-V M-extension reference semantics.
  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output int lat);
    int sa;
    int sbv;
    sa  = a;
    sbv = b;
    lat = 33;
    if (b == 32'd0) begin
      q   = 32'hFFFF_FFFF;
      r   = a;
      lat = 0;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q   = 32'h8000_0000;
      r   = 32'd0;
      lat = 0;
    end else if (s) begin
      q = sa / sbv;
      r = sa % sbv;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Monitor: compare fresh results, police the busy window, record accepts.
  always @(negedge clk) begin
    exp_t e;
    logic new_res;
    if (rst) begin
      prev_done = 1'b0;
      prev_acc  = 1'b0;
    end else begin
      new_res = done_o && (!prev_done || prev_acc);
      if (new_res) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_done: got done with empty scoreboard, required none (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          n_txn++;
          $display("txn %0d s=%0b a=%h b=%h -> q=%h r=%h lat=%0d", n_txn, e.s, e.a, e.b,
                   quotient_o, remainder_o, cyc - e.acc);
          chk("quotient", quotient_o, e.q);
          chk("remainder", remainder_o, e.r);
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("ready_with_done", {31'd0, ready_o}, 32'd1);
        end
      end else if (sb.size() != 0) begin
        chk("busy_ready_done", {30'd0, ready_o, done_o}, 32'd0);
      end
      if (ready_o && start_i) begin
        ref_div(signed_i, dividend_i, divisor_i, e.q, e.r, e.lat);
        e.s   = signed_i;
        e.a   = dividend_i;
        e.b   = divisor_i;
        e.acc = cyc + 1;
        sb.push_back(e);
      end
      prev_done = done_o;
      prev_acc  = ready_o && start_i;
    end
  end

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'd1;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h8000_0000;
      4:       v = 32'h7FFF_FFFF;
      5:       v = 32'($urandom_range(0, 255));
      default: v = $urandom();
    endcase
    return v;
  endfunction

  task automatic drain(input int limit);
    int k;
    k = 0;
    while (sb.size() != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending results after %0d cycles, required 0", sb.size(), limit);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    signed_i   = s;
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic single(input logic s, input logic [31:0] a, input logic [31:0] b);
    issue(s, a, b);
    drain(60);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    start_i    = 1'b0;
    signed_i   = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    #12;
    chk("reset_ready", {31'd0, ready_o}, 32'd1);
    chk("reset_done", {31'd0, done_o}, 32'd0);
    chk("reset_quotient", quotient_o, 32'd0);
    chk("reset_remainder", remainder_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed cases: regular, signed mixes, divide by zero, overflow.
    single(1'b0, 32'd100, 32'd7);
    single(1'b1, 32'hFFFF_FFF9, 32'd2);
    single(1'b1, 32'd7, 32'hFFFF_FFFE);
    single(1'b1, 32'd5, 32'd0);
    single(1'b0, 32'd5, 32'd0);
    single(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    single(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);

    // A start pulse while busy must be ignored.
    issue(1'b0, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    signed_i   = 1'b1;
    dividend_i = 32'd12345;
    divisor_i  = 32'd0;
    start_i    = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    drain(60);

    // Asynchronous reset in the middle of an operation.
    issue(1'b0, 32'hDEAD_BEEF, 32'd13);
    repeat (19) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_ready", {31'd0, ready_o}, 32'd1);
    chk("async_rst_done", {31'd0, done_o}, 32'd0);
    chk("async_rst_quotient", quotient_o, 32'd0);
    chk("async_rst_remainder", remainder_o, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    single(1'b1, 32'hFFFF_FC18, 32'd7);

    // Back-to-back random operations with start held high.
    @(posedge clk);
    #1;
    signed_i   = 1'($urandom_range(0, 1));
    dividend_i = pick();
    divisor_i  = pick();
    start_i    = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      int k;
      k = 0;
      @(negedge clk);
      while (!ready_o && k < 100) begin
        @(negedge clk);
        k++;
      end
      if (!ready_o) begin
        n_vec++;
        n_bad++;
        $display("FAIL b2b_ready_timeout: got ready_o=%0b after %0d cycles, required 1", ready_o, k);
        break;
      end
      @(posedge clk);
      #1;
      if (i < 999) begin
        signed_i   = 1'($urandom_range(0, 1));
        dividend_i = pick();
        divisor_i  = pick();
      end else begin
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    drain(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
